// File: rtl/mod_pkg.sv
// Shared types and constants for the sequential modular reducer.
// DEFAULT_P is the 256-bit prime modulus used by the default configuration.
package mod_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam logic [255:0] DEFAULT_P =
      256'd104899928942039473597645237135751317405745389583683433800060134911610808289117;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(v)) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mod_step.sv
// One restoring-reduction step: r' = 2r + bit, minus p when r' >= p.
// Purely combinational; relies on r < p so a single subtract is enough.
module mod_step #(
   parameter int P_W = 256
) (
   input  logic [P_W-1:0] r_i,
   input  logic           bit_i,
   input  logic [P_W-1:0] p_i,
   output logic [P_W-1:0] r_o
);

   logic [P_W:0] t;
   logic         ge;

   // 2r+1 < 2p fits in P_W+1 bits, and the reduced value is below p, so the
   // low P_W bits of the subtraction are exact.
   assign t   = {r_i, bit_i};
   assign ge  = (t >= {1'b0, p_i});
   assign r_o = ge ? (t[P_W-1:0] - p_i) : t[P_W-1:0];

endmodule

// File: rtl/mod_reduce_seq.sv
// Bit-serial o = x mod p, BPC dividend bits per cycle; result after IN_W/BPC cycles (p==0 flagged at once).
// One op in flight: in_ready only in IDLE; out_ready low holds DONE with o/err stable.
module mod_reduce_seq
   import mod_pkg::*;
#(
   parameter int IN_W = 300,
   parameter int P_W  = 256,
   parameter int BPC  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] x,
   input  logic [P_W-1:0]  p,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [P_W-1:0]  o,
   output logic            err
);

   localparam int N     = IN_W / BPC;
   localparam int CNT_W = (clog2(N + 1) < 1) ? 1 : clog2(N + 1);

   generate
      if (IN_W % BPC != 0) begin : g_bad_bpc
         $error("mod_reduce_seq: IN_W must be a multiple of BPC");
      end
   endgenerate

   state_e           state_q, state_d;
   logic [IN_W-1:0]  xs_q, xs_d;
   logic [P_W-1:0]   pr_q, pr_d;
   logic [P_W-1:0]   r_q, r_d;
   logic [P_W-1:0]   o_q, o_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             p_zero;
   logic             last;
   logic [P_W-1:0]   rc [BPC+1];

   assign accept = in_valid && in_ready;
   assign p_zero = (p == '0);
   assign last   = (cnt_q == CNT_W'(1));
   assign rc[0]  = r_q;

   // Chain of BPC steps per cycle, consuming the dividend MSB first.
   for (genvar k = 0; k < BPC; k++) begin : g_step
      mod_step #(.P_W(P_W)) u_step (
         .r_i   (rc[k]),
         .bit_i (xs_q[IN_W-1-k]),
         .p_i   (pr_q),
         .r_o   (rc[k+1])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = p_zero ? DONE : RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   always_comb begin
      xs_d  = xs_q;
      pr_d  = pr_q;
      r_d   = r_q;
      cnt_d = cnt_q;
      o_d   = o_q;
      err_d = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               xs_d  = x;
               pr_d  = p;
               r_d   = '0;
               cnt_d = CNT_W'(N);
               if (p_zero) begin
                  o_d   = '0;
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            xs_d  = xs_q << BPC;
            r_d   = rc[BPC];
            cnt_d = cnt_q - CNT_W'(1);
            if (last) begin
               o_d   = rc[BPC];
               err_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xs_q  <= '0;
         pr_q  <= '0;
         r_q   <= '0;
         cnt_q <= '0;
         o_q   <= '0;
         err_q <= 1'b0;
      end else begin
         xs_q  <= xs_d;
         pr_q  <= pr_d;
         r_q   <= r_d;
         cnt_q <= cnt_d;
         o_q   <= o_d;
         err_q <= err_d;
      end
   end

   assign o   = o_q;
   assign err = err_q;

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed table plus hand sequences for mod_reduce_seq in three configurations.
module tb_mod_reduce_seq;
   import mod_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [299:0] x_s = '0;
   logic [255:0] p_s = '0;
   logic         iv_a = 0, iv_b = 0, iv_c = 0;
   logic         or_a = 0, or_b = 0, or_c = 0;
   logic         ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, er_a, er_b, er_c;
   logic [3:0]   o_a, o_b;
   logic [255:0] o_c;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mod_reduce_seq #(.IN_W(8), .P_W(4), .BPC(1)) u_a (
      .clk(clk), .reset(reset), .in_valid(iv_a), .in_ready(ir_a), .x(x_s[7:0]), .p(p_s[3:0]),
      .out_valid(ov_a), .out_ready(or_a), .o(o_a), .err(er_a));
   mod_reduce_seq #(.IN_W(8), .P_W(4), .BPC(4)) u_b (
      .clk(clk), .reset(reset), .in_valid(iv_b), .in_ready(ir_b), .x(x_s[7:0]), .p(p_s[3:0]),
      .out_valid(ov_b), .out_ready(or_b), .o(o_b), .err(er_b));
   mod_reduce_seq u_c (
      .clk(clk), .reset(reset), .in_valid(iv_c), .in_ready(ir_c), .x(x_s), .p(p_s),
      .out_valid(ov_c), .out_ready(or_c), .o(o_c), .err(er_c));

   typedef struct {
      int           sel;
      logic [299:0] x;
      logic [255:0] p;
      logic [255:0] o;
      logic         err;
      int           lat;
   } vec_t;

   vec_t tbl [12];

   function automatic logic get_ov(input int s);
      case (s) 0: return ov_a; 1: return ov_b; default: return ov_c; endcase
   endfunction
   function automatic logic get_ir(input int s);
      case (s) 0: return ir_a; 1: return ir_b; default: return ir_c; endcase
   endfunction
   function automatic logic get_er(input int s);
      case (s) 0: return er_a; 1: return er_b; default: return er_c; endcase
   endfunction
   function automatic logic [255:0] get_o(input int s);
      case (s) 0: return {252'd0, o_a}; 1: return {252'd0, o_b}; default: return o_c; endcase
   endfunction

   task automatic set_iv(input int s, input logic v);
      case (s) 0: iv_a = v; 1: iv_b = v; default: iv_c = v; endcase
   endtask
   task automatic set_or(input int s, input logic v);
      case (s) 0: or_a = v; 1: or_b = v; default: or_c = v; endcase
   endtask

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Issue one op and wait for its result; lat < 0 means "within one cycle".
   task automatic run_op(input int s, input logic [299:0] xv, input logic [255:0] pv,
                         input logic [255:0] eo, input logic ee, input int lat, input string nm);
      int cyc;
      x_s = xv;
      p_s = pv;
      set_iv(s, 1'b1);
      chk({nm, " in_ready"}, 256'(get_ir(s)), 256'd1);
      @(posedge clk); #1;
      set_iv(s, 1'b0);
      x_s = ~xv;
      p_s = ~pv;
      cyc = 0;
      while (!get_ov(s) && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (lat >= 0) chk({nm, " latency"}, 256'(cyc), 256'(lat));
      else          chk({nm, " latency<=1"}, 256'(cyc <= 1), 256'd1);
      chk({nm, " o"}, get_o(s), eo);
      chk({nm, " err"}, 256'(get_er(s)), 256'(ee));
      set_or(s, 1'b1);
      @(posedge clk); #1;
      set_or(s, 1'b0);
      chk({nm, " out_valid cleared"}, 256'(get_ov(s)), 256'd0);
      chk({nm, " in_ready back"}, 256'(get_ir(s)), 256'd1);
   endtask

   initial begin
      logic [299:0] rx;
      logic [299:0] rexp;

      tbl[0]  = '{0, 300'd200, 256'd7,  256'd4, 1'b0, 8};
      tbl[1]  = '{0, 300'd5,   256'd7,  256'd5, 1'b0, 8};
      tbl[2]  = '{0, 300'd255, 256'd15, 256'd0, 1'b0, 8};
      tbl[3]  = '{1, 300'd255, 256'd13, 256'd8, 1'b0, 2};
      tbl[4]  = '{1, 300'd3,   256'd13, 256'd3, 1'b0, 2};
      tbl[5]  = '{1, 300'd128, 256'd15, 256'd8, 1'b0, 2};
      tbl[6]  = '{0, 300'd123, 256'd0,  256'd0, 1'b1, -1};
      tbl[7]  = '{0, 300'd123, 256'd1,  256'd0, 1'b0, 8};
      tbl[8]  = '{2, 300'(DEFAULT_P) + 300'd5, DEFAULT_P, 256'd5, 1'b0, 300};
      tbl[9]  = '{2, 300'd0, DEFAULT_P, 256'd0, 1'b0, 300};
      tbl[10] = '{2, 300'(DEFAULT_P) * 300'd2, DEFAULT_P, 256'd0, 1'b0, 300};
      tbl[11] = '{2, 300'd7, 256'd0, 256'd0, 1'b1, -1};

      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         chk("reset out_valid", 256'(get_ov(s)), 256'd0);
         chk("reset o", get_o(s), 256'd0);
         chk("reset err", 256'(get_er(s)), 256'd0);
      end
      reset = 1'b0;
      #1;
      chk("in_ready after reset", 256'({ir_a, ir_b, ir_c}), 256'd7);

      for (int i = 0; i < 12; i++)
         run_op(tbl[i].sel, tbl[i].x, tbl[i].p, tbl[i].o, tbl[i].err, tbl[i].lat,
                $sformatf("vec%0d", i));

      // Backpressure: result held in DONE, new requests ignored.
      x_s = 300'd200;
      p_s = 256'd7;
      iv_a = 1'b1;
      @(posedge clk); #1;
      x_s = 300'd99;
      p_s = 256'd5;
      for (int c = 0; c < 20 && !ov_a; c++) begin
         @(posedge clk); #1;
      end
      for (int c = 0; c < 5; c++) begin
         chk("bp out_valid", 256'(ov_a), 256'd1);
         chk("bp o", 256'(o_a), 256'd4);
         chk("bp err", 256'(er_a), 256'd0);
         chk("bp in_ready", 256'(ir_a), 256'd0);
         @(posedge clk); #1;
      end
      or_a = 1'b1;
      iv_a = 1'b0;
      @(posedge clk); #1;
      or_a = 1'b0;
      chk("bp release out_valid", 256'(ov_a), 256'd0);
      chk("bp release in_ready", 256'(ir_a), 256'd1);

      // Reset during RUN aborts the op with no later result.
      x_s = 300'd200;
      p_s = 256'd7;
      iv_a = 1'b1;
      @(posedge clk); #1;
      iv_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre-abort in_ready", 256'(ir_a), 256'd0);
      reset = 1'b1;
      #1;
      chk("abort out_valid", 256'(ov_a), 256'd0);
      chk("abort o", 256'(o_a), 256'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort in_ready", 256'(ir_a), 256'd1);
      begin
         logic seen;
         seen = 1'b0;
         repeat (10) begin
            @(posedge clk); #1;
            seen = seen | ov_a;
         end
         chk("abort no result", 256'(seen), 256'd0);
      end
      run_op(0, 300'd100, 256'd9, 256'd1, 1'b0, 8, "after abort");

      // Random wide dividends against the default prime.
      for (int i = 0; i < 150; i++) begin
         rx = {$urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom};
         if (i == 0) rx = '1;
         rexp = rx % 300'(DEFAULT_P);
         run_op(2, rx, DEFAULT_P, rexp[255:0], 1'b0, 300, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
